// File: rtl/espirometro_medicion.sv
// Spirometry measurement engine: waits for breath onset, integrates flow, tracks peak flow, flags end of expiration.
// Optional FEV1 capture is enabled by defining ESPIRO_FEV1_EN.
module espirometro_medicion #(
  parameter int FLOW_W       = 10,
  parameter int VOL_W        = 24,
  parameter int CNT_W        = 16,
  parameter int START_TH     = 40,
  parameter int STOP_TH      = 20,
  parameter int STOP_SAMPLES = 16,
  parameter int MAX_SAMPLES  = 6000,
  parameter int FEV1_SAMPLES = 1000
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iCE,
  input  logic [FLOW_W-1:0] ivFlujo,
  input  logic              iArm,
  output logic              oBusy,
  output logic              oMidiendo,
  output logic              oDone,
  output logic              oSat,
  output logic [VOL_W-1:0]  ovVolumen,
  output logic [FLOW_W-1:0] ovPico,
  output logic [CNT_W-1:0]  ovMuestras
`ifdef ESPIRO_FEV1_EN
  ,
  output logic [VOL_W-1:0]  ovFEV1
`endif
);

  localparam int BAJO_W = $clog2(STOP_SAMPLES + 1);
  localparam logic [FLOW_W-1:0] START_V = FLOW_W'(START_TH);
  localparam logic [FLOW_W-1:0] STOP_V  = FLOW_W'(STOP_TH);
  localparam logic [BAJO_W-1:0] BAJO_FIN = BAJO_W'(STOP_SAMPLES);
  localparam logic [CNT_W-1:0]  MUES_FIN = CNT_W'(MAX_SAMPLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MEAS} state_t;

  state_t              state_q, state_d;
  logic [VOL_W-1:0]    vol_q, vol_d;
  logic [FLOW_W-1:0]   pico_q, pico_d;
  logic [CNT_W-1:0]    mues_q, mues_d;
  logic [BAJO_W-1:0]   bajo_q, bajo_d;
  logic                sat_q, sat_d;
  logic                done_q, done_d;

  logic                start_smp, meas_smp, fin;
  logic [VOL_W:0]      suma;
  logic [VOL_W-1:0]    vol_b, vol_n;
  logic [FLOW_W-1:0]   pico_b;
  logic [CNT_W-1:0]    mues_b, mues_n;
  logic [BAJO_W-1:0]   bajo_b, bajo_n;
  logic                sat_b;

  // The qualifying onset sample is processed on top of cleared results.
  always_comb begin
    start_smp = iCE && (state_q == S_WAIT) && (ivFlujo >= START_V);
    meas_smp  = iCE && ((state_q == S_MEAS) || start_smp);
    vol_b     = start_smp ? '0   : vol_q;
    pico_b    = start_smp ? '0   : pico_q;
    mues_b    = start_smp ? '0   : mues_q;
    bajo_b    = start_smp ? '0   : bajo_q;
    sat_b     = start_smp ? 1'b0 : sat_q;
    suma      = {1'b0, vol_b} + (VOL_W+1)'(ivFlujo);
    vol_n     = suma[VOL_W] ? '1 : suma[VOL_W-1:0];
    mues_n    = mues_b + 1'b1;
    bajo_n    = (ivFlujo < STOP_V) ? bajo_b + 1'b1 : '0;
    fin       = (bajo_n == BAJO_FIN) || (mues_n == MUES_FIN);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iArm) state_d = S_WAIT;
      S_WAIT:  if (start_smp) state_d = fin ? S_IDLE : S_MEAS;
      S_MEAS:  if (meas_smp && fin) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vol_d  = vol_q;
    pico_d = pico_q;
    mues_d = mues_q;
    bajo_d = bajo_q;
    sat_d  = sat_q;
    done_d = 1'b0;
    if (meas_smp) begin
      vol_d  = vol_n;
      pico_d = (ivFlujo > pico_b) ? ivFlujo : pico_b;
      mues_d = mues_n;
      bajo_d = bajo_n;
      sat_d  = sat_b | suma[VOL_W];
      done_d = fin;
    end
  end

`ifdef ESPIRO_FEV1_EN
  localparam logic [CNT_W-1:0] FEV1_FIN = CNT_W'(FEV1_SAMPLES);
  logic [VOL_W-1:0] fev1_q, fev1_d;
  logic             hit_q, hit_d;
  logic             hit_b;

  // Short tests that never reach the 1 s mark report their final volume.
  always_comb begin
    hit_b  = start_smp ? 1'b0 : hit_q;
    fev1_d = start_smp ? '0 : fev1_q;
    hit_d  = hit_b;
    if (meas_smp && !hit_b) begin
      if ((mues_n == FEV1_FIN) || fin) fev1_d = vol_n;
      if (mues_n == FEV1_FIN) hit_d = 1'b1;
    end
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      fev1_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      fev1_q <= fev1_d;
      hit_q  <= hit_d;
    end
  end

  assign ovFEV1 = fev1_q;
`endif

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q <= S_IDLE;
      vol_q   <= '0;
      pico_q  <= '0;
      mues_q  <= '0;
      bajo_q  <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vol_q   <= vol_d;
      pico_q  <= pico_d;
      mues_q  <= mues_d;
      bajo_q  <= bajo_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    oBusy      = (state_q != S_IDLE);
    oMidiendo  = (state_q == S_MEAS);
    oDone      = done_q;
    oSat       = sat_q;
    ovVolumen  = vol_q;
    ovPico     = pico_q;
    ovMuestras = mues_q;
  end

endmodule

// File: tb/tb_espirometro_medicion.sv
// Directed bench for espirometro_medicion: table of whole-test vectors plus hand sequences for corners.
module tb_espirometro_medicion;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ce, arm;
  logic [9:0] flujo;

  logic        busy, midiendo, done, sat;
  logic [23:0] vol;
  logic [9:0]  pico;
  logic [15:0] mues;

  logic        s_busy, s_midiendo, s_done, s_sat;
  logic [9:0]  s_vol;
  logic [9:0]  s_pico;
  logic [15:0] s_mues;

  espirometro_medicion dut (
    .iClk(clk), .iReset(rst), .iCE(ce), .ivFlujo(flujo), .iArm(arm),
    .oBusy(busy), .oMidiendo(midiendo), .oDone(done), .oSat(sat),
    .ovVolumen(vol), .ovPico(pico), .ovMuestras(mues)
`ifdef ESPIRO_FEV1_EN
    , .ovFEV1(fev1)
`endif
  );

  espirometro_medicion #(.VOL_W(10), .MAX_SAMPLES(8)) dut_s (
    .iClk(clk), .iReset(rst), .iCE(ce), .ivFlujo(flujo), .iArm(arm),
    .oBusy(s_busy), .oMidiendo(s_midiendo), .oDone(s_done), .oSat(s_sat),
    .ovVolumen(s_vol), .ovPico(s_pico), .ovMuestras(s_mues)
`ifdef ESPIRO_FEV1_EN
    , .ovFEV1(s_fev1)
`endif
  );

`ifdef ESPIRO_FEV1_EN
  logic [23:0] fev1, s_fev1, f_fev1, f_vol;
  logic        f_busy, f_midiendo, f_done, f_sat;
  logic [9:0]  f_pico;
  logic [15:0] f_mues;

  espirometro_medicion #(.FEV1_SAMPLES(8)) dut_f (
    .iClk(clk), .iReset(rst), .iCE(ce), .ivFlujo(flujo), .iArm(arm),
    .oBusy(f_busy), .oMidiendo(f_midiendo), .oDone(f_done), .oSat(f_sat),
    .ovVolumen(f_vol), .ovPico(f_pico), .ovMuestras(f_mues), .ovFEV1(f_fev1)
  );
`endif

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input int v);
    ce    = 1'b1;
    flujo = v[9:0];
    cyc();
    ce    = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  typedef struct {
    int f[4];
    int n[4];
    int e_len;
    int e_vol;
    int e_pico;
    int e_mues;
    int e_sat;
  } vec_t;

  vec_t tv[3];

  initial begin
    int k, done_at, dones;

    // 30x10 preamble, 100x50, 0x16
    tv[0].f = '{30, 100, 0, 0};   tv[0].n = '{10, 50, 16, 0};
    tv[0].e_len = 76; tv[0].e_vol = 5000; tv[0].e_pico = 100; tv[0].e_mues = 66; tv[0].e_sat = 0;
    // ramp 40..400 step 20 (sum 19*220 = 4180) then 10x16 (160)
    tv[1].f = '{0, 0, 10, 0};     tv[1].n = '{0, 0, 16, 0};
    tv[1].e_len = 35; tv[1].e_vol = 4340; tv[1].e_pico = 400; tv[1].e_mues = 35; tv[1].e_sat = 0;
    // dip of 15 low samples must not end the test
    tv[2].f = '{100, 0, 100, 0};  tv[2].n = '{5, 15, 5, 16};
    tv[2].e_len = 41; tv[2].e_vol = 1000; tv[2].e_pico = 100; tv[2].e_mues = 41; tv[2].e_sat = 0;

    rst = 1'b1; ce = 1'b0; arm = 1'b0; flujo = '0;
    cyc(); cyc();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_vol", vol, 0);
    chk("reset_mues", mues, 0);
    rst = 1'b0;
    cyc();
    smp(100);
    cyc();
    chk("idle_ce_busy", busy, 0);
    chk("idle_ce_mues", mues, 0);

    for (int t = 0; t < 3; t++) begin
      do_arm();
      chk($sformatf("v%0d_armed_busy", t), busy, 1);
      chk($sformatf("v%0d_armed_meas", t), midiendo, 0);
      k = 0; done_at = 0; dones = 0;
      if (t == 1) begin
        for (int r = 0; r < 19; r++) begin
          smp(40 + 20 * r); k++;
          if (done) begin dones++; done_at = k; end
          cyc();
          if (done) dones++;
        end
      end
      for (int s = 0; s < 4; s++) begin
        for (int i = 0; i < tv[t].n[s]; i++) begin
          smp(tv[t].f[s]); k++;
          if (done) begin dones++; done_at = k; end
          cyc();
          if (done) dones++;
        end
      end
      chk($sformatf("v%0d_done_at", t), done_at, tv[t].e_len);
      chk($sformatf("v%0d_done_cnt", t), dones, 1);
      chk($sformatf("v%0d_vol", t), vol, tv[t].e_vol);
      chk($sformatf("v%0d_pico", t), pico, tv[t].e_pico);
      chk($sformatf("v%0d_mues", t), mues, tv[t].e_mues);
      chk($sformatf("v%0d_sat", t), sat, tv[t].e_sat);
      chk($sformatf("v%0d_idle", t), busy, 0);
    end

    // results hold after the test, iCE in IDLE ignored
    repeat (4) cyc();
    smp(300);
    cyc();
    chk("hold_vol", vol, 1000);
    chk("hold_pico", pico, 100);

    // abort and re-arm while busy
    do_arm();
    smp(30);
    chk("wait_not_meas", midiendo, 0);
    repeat (5) smp(100);
    chk("meas_flag", midiendo, 1);
    chk("meas_mues5", mues, 5);
    arm = 1'b1;
    smp(100);
    arm = 1'b0;
    cyc();
    chk("rearm_ignored_mues", mues, 6);
    chk("rearm_ignored_vol", vol, 600);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_vol", vol, 0);
    chk("abort_mues", mues, 0);
    cyc();
    rst = 1'b0;
    dones = 0;
    repeat (4) begin
      cyc();
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);

    // sample limit and saturation on the narrow instance
    do_arm();
    done_at = 0; dones = 0;
    for (int i = 1; i <= 8; i++) begin
      smp(200);
      if (s_done) begin dones++; done_at = i; end
      cyc();
      if (s_done) dones++;
    end
    chk("max_done_at", done_at, 8);
    chk("max_done_cnt", dones, 1);
    chk("max_sat", s_sat, 1);
    chk("max_vol", s_vol, 1023);
    chk("max_mues", s_mues, 8);
    chk("max_idle", s_busy, 0);
    chk("wide_no_sat", sat, 0);
    chk("wide_vol", vol, 1600);
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    do_arm();
    smp(100);
    chk("sat_cleared", s_sat, 0);
    chk("sat_new_vol", s_vol, 100);

`ifdef ESPIRO_FEV1_EN
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    do_arm();
    dones = 0;
    repeat (20) begin smp(100); cyc(); end
    repeat (16) begin smp(0); if (f_done) dones++; cyc(); end
    chk("fev1_long_done", dones, 1);
    chk("fev1_long", f_fev1, 800);
    chk("fev1_long_vol", f_vol, 2000);
    do_arm();
    dones = 0;
    repeat (3) begin smp(100); cyc(); end
    repeat (16) begin smp(0); if (f_done) dones++; cyc(); end
    chk("fev1_short_done", dones, 1);
    chk("fev1_short", f_fev1, 300);
    chk("fev1_short_vol", f_vol, 300);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
